// File: rtl/mem_wait_responder_if.sv
// ============================================================================
// Module      : mem_wait_responder_if
// Description : Processor-to-data-memory request/response bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_wait_responder_if;
    logic [31:0] adr;
    logic [31:0] data_in;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] data_out;
    logic        mem_ready;
    logic        mem_err;

    modport master (
        output adr,
        output data_in,
        output MemRead,
        output MemWrite,
        input  data_out,
        input  mem_ready,
        input  mem_err
    );

    modport slave (
        input  adr,
        input  data_in,
        input  MemRead,
        input  MemWrite,
        output data_out,
        output mem_ready,
        output mem_err
    );
endinterface

`default_nettype wire

// File: rtl/mem_wait_responder.sv
// ============================================================================
// Module      : mem_wait_responder
// Description : Word-organised data memory that completes each access after
//               LATENCY edges and flags it with a one-cycle mem_ready pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mem_wait_responder_if.slave bus
);

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [3:0]       cnt_q,       cnt_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic [31:0]      wdata_q,     wdata_d;
    logic             is_wr_q,     is_wr_d;
    logic             bad_q,       bad_d;
    logic [31:0]      data_out_q,  data_out_d;
    logic             mem_ready_q, mem_ready_d;
    logic             mem_err_q,   mem_err_d;
    logic             mem_we;

    logic [31:0]      mem_q [DEPTH_WORDS];

    logic             req;
    logic             req_both;
    logic             req_misalign;
    logic             req_range;
    logic             req_bad;

    assign req          = bus.MemRead | bus.MemWrite;
    assign req_both     = bus.MemRead & bus.MemWrite;
    assign req_misalign = |bus.adr[1:0];
    assign req_range    = {2'b00, bus.adr[31:2]} >= 32'(DEPTH_WORDS);
    assign req_bad      = req_both | req_misalign | req_range;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        is_wr_d     = is_wr_q;
        bad_d       = bad_q;
        data_out_d  = data_out_q;
        mem_ready_d = 1'b0;
        mem_err_d   = 1'b0;
        mem_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    // A rejected request latches index 0 so the array is never
                    // addressed out of bounds, even for non-power-of-two depths.
                    idx_d   = req_bad ? '0 : bus.adr[IDX_W+1:2];
                    wdata_d = bus.data_in;
                    is_wr_d = bus.MemWrite;
                    bad_d   = req_bad;
                    cnt_d   = CNT_LOAD;
                    state_d = S_BUSY;
                end
            end

            S_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d     = S_DONE;
                    mem_ready_d = 1'b1;
                    mem_err_d   = bad_q;
                    if (bad_q) begin
                        data_out_d = '0;
                    end else if (is_wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        data_out_d = mem_q[idx_q];
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            wdata_q     <= 32'd0;
            is_wr_q     <= 1'b0;
            bad_q       <= 1'b0;
            data_out_q  <= 32'd0;
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            is_wr_q     <= is_wr_d;
            bad_q       <= bad_d;
            data_out_q  <= data_out_d;
            mem_ready_q <= mem_ready_d;
            mem_err_q   <= mem_err_d;
        end
    end

    // Storage keeps its contents across reset; mem_we is already forced low
    // by the async reset of the control state.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.mem_ready = mem_ready_q;
    assign bus.mem_err   = mem_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_wait_responder.sv
// ============================================================================
// Module      : tb_mem_wait_responder
// Description : Directed self-checking bench for mem_wait_responder at
//               LATENCY=3 and LATENCY=1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wait_responder;

    logic clk;
    logic rst;
    int   tests;
    int   failed;

    mem_wait_responder_if bus3();
    mem_wait_responder_if bus1();

    mem_wait_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    mem_wait_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus3.MemRead = rd; bus3.MemWrite = wr; bus3.adr = a; bus3.data_in = d;
        end else begin
            bus1.MemRead = rd; bus1.MemWrite = wr; bus1.adr = a; bus1.data_in = d;
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? bus3.mem_ready : bus1.mem_ready;
    endfunction

    // Issues one request, holds it until mem_ready, then drops it.
    // lat = edges after the acceptance edge until mem_ready is seen (-1 on timeout);
    // one_shot = mem_ready low one edge after it was seen.
    task automatic access(input int sel, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] dout, output logic err,
                          output int lat, output logic one_shot);
        int n;
        @(negedge clk);
        drive(sel, rd, wr, a, d);
        n   = 0;
        lat = -1;
        while (n < 40 && lat < 0) begin
            @(posedge clk); #1;
            if (rdy(sel)) lat = n;
            n++;
        end
        dout = (sel == 0) ? bus3.data_out : bus1.data_out;
        err  = (sel == 0) ? bus3.mem_err  : bus1.mem_err;
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        one_shot = !rdy(sel);
    endtask

    initial begin
        logic [31:0] dout;
        logic        err;
        logic        one;
        int          lat;
        int          t1;
        int          t2;
        int          seen;

        tests  = 0;
        failed = 0;
        rst    = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", bus3.data_out, 32'd0);
        check("reset_ready",    32'(bus3.mem_ready), 32'd0);
        check("reset_err",      32'(bus3.mem_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, dout, err, lat, one);
        check("wr10_latency", 32'(lat), 32'd3);
        check("wr10_err",     32'(err), 32'd0);
        check("wr10_dout",    dout, 32'd0);
        check("wr10_pulse",   32'(one), 32'd1);
        access(0, 1'b1, 1'b0, 32'h10, 32'd0, dout, err, lat, one);
        check("rd10_data",    dout, 32'hDEADBEEF);
        check("rd10_latency", 32'(lat), 32'd3);

        access(0, 1'b0, 1'b1, 32'h0, 32'h11111111, dout, err, lat, one);
        access(0, 1'b0, 1'b1, 32'h4, 32'h22222222, dout, err, lat, one);
        access(0, 1'b1, 1'b0, 32'h4, 32'd0, dout, err, lat, one);
        check("rd4_data", dout, 32'h22222222);
        access(0, 1'b1, 1'b0, 32'h0, 32'd0, dout, err, lat, one);
        check("rd0_data", dout, 32'h11111111);

        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h4, 32'd0);
        t1 = -1;
        t2 = -1;
        for (int c = 0; c < 40 && t2 < 0; c++) begin
            @(posedge clk); #1;
            if (bus3.mem_ready) begin
                if (t1 < 0) t1 = c;
                else        t2 = c;
            end
        end
        check("held_spacing", 32'(t2 - t1), 32'd5);
        check("held_data",    bus3.data_out, 32'h22222222);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);

        access(0, 1'b1, 1'b0, 32'h13, 32'd0, dout, err, lat, one);
        check("misalign_err",     32'(err), 32'd1);
        check("misalign_dout",    dout, 32'd0);
        check("misalign_latency", 32'(lat), 32'd3);

        access(0, 1'b0, 1'b1, 32'd4096, 32'hFFFFFFFF, dout, err, lat, one);
        check("oor_err", 32'(err), 32'd1);
        access(0, 1'b1, 1'b0, 32'h0, 32'd0, dout, err, lat, one);
        check("oor_word0", dout, 32'h11111111);
        check("good_err",  32'(err), 32'd0);

        access(0, 1'b0, 1'b1, 32'h8, 32'hA5A5A5A5, dout, err, lat, one);
        access(0, 1'b1, 1'b1, 32'h8, 32'h0, dout, err, lat, one);
        check("both_err",  32'(err), 32'd1);
        check("both_dout", dout, 32'd0);
        access(0, 1'b1, 1'b0, 32'h8, 32'd0, dout, err, lat, one);
        check("both_word8", dout, 32'hA5A5A5A5);

        access(0, 1'b0, 1'b1, 32'h20, 32'h00000055, dout, err, lat, one);
        check("wr20_dout_hold", dout, 32'hA5A5A5A5);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'h20, 32'h12345678);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("midrst_dout",  bus3.data_out, 32'd0);
        check("midrst_ready", 32'(bus3.mem_ready), 32'd0);
        check("midrst_err",   32'(bus3.mem_err), 32'd0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus3.mem_ready) seen++;
            if (c == 1) rst = 1'b0;
        end
        check("midrst_no_pulse", 32'(seen), 32'd0);
        access(0, 1'b1, 1'b0, 32'h20, 32'd0, dout, err, lat, one);
        check("midrst_word20", dout, 32'h00000055);

        access(1, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, dout, err, lat, one);
        check("l1_wr_latency", 32'(lat), 32'd1);
        check("l1_wr_pulse",   32'(one), 32'd1);
        access(1, 1'b1, 1'b0, 32'h40, 32'd0, dout, err, lat, one);
        check("l1_rd_data",    dout, 32'hCAFEF00D);
        check("l1_rd_latency", 32'(lat), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_wait_responder.md
Name: mem_wait_responder

Overview:
- Data-memory responder for the multi-cycle MIPS core.
- Accepts MemRead/MemWrite requests and owns a word-organised storage array.
- Completes each access after a fixed, configurable number of wait cycles and signals completion with a one-cycle mem_ready pulse.
- Lets the processor's memory states be exercised against realistic memory latency instead of a zero-wait memory.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; valid word index 0..DEPTH_WORDS-1
LATENCY, 3, clock edges from request acceptance to access; legal range 1..15

Ports:
clk       input   1   clock, rising-edge active
rst       input   1   asynchronous, active-high reset
adr       input   32  byte address from processor
data_in   input   32  write data from processor
MemRead   input   1   read request, level
MemWrite  input   1   write request, level
data_out  output  32  read data to processor (registered)
mem_ready output  1   access complete, one-cycle pulse
mem_err   output  1   access rejected; valid only while mem_ready=1

Behaviour:
- Reset (rst=1, async): state=IDLE, cnt=0, data_out=0, mem_ready=0, mem_err=0.
- Array contents are not cleared by reset.
- States:
  - IDLE: at a rising edge with MemRead|MemWrite=1:
    - latch adr, data_in and op;
    - latch bad = (MemRead&MemWrite) | (adr[1:0]!=0) | (adr[31:2]>=DEPTH_WORDS);
    - cnt<=LATENCY-1; go to BUSY.
  - BUSY: at each edge, if cnt!=0 then cnt<=cnt-1; else perform the access and go to DONE.
  - DONE: mem_ready=1, mem_err=bad. The next edge returns to IDLE unconditionally.
- Access rules (performed at the BUSY->DONE edge):
  - Good write: array[adr[31:2]] <= latched data_in. data_out is unchanged.
  - Good read: data_out <= array[adr[31:2]].
  - Bad request: no array write; data_out <= 0.
- Timing:
  - If the request is accepted at edge E0, the access happens at edge E0+LATENCY.
  - mem_ready is high from E0+LATENCY until E0+LATENCY+1.
  - Next acceptance is possible at E0+LATENCY+2 at the earliest.
- Handshake:
  - The processor holds the request until it samples mem_ready=1.
  - A request still high in IDLE after DONE is treated as a new request.
  - adr, data_in and request changes during BUSY/DONE are ignored, since inputs are latched at acceptance.
- Simultaneous MemRead&MemWrite: treated as a bad request. Full latency still elapses, then mem_ready=1 and mem_err=1; no array change.
- data_out holds the last completed read value (or 0 after a bad access) until the next read completes.
- Reset mid-operation: if asserted before the access edge, the access is aborted and the array is unchanged. The FSM returns to IDLE; mem_ready is not pulsed.
- mem_ready and mem_err are registered state decodes with no combinational path from the inputs.

Test Plan:
- LATENCY=3: write 0xDEADBEEF to adr 0x10 with MemWrite accepted at E0 -> mem_ready=1 exactly during E3..E4, mem_err=0, data_out unchanged. Then read 0x10 -> data_out=0xDEADBEEF with mem_ready.
- Back-to-back: write 0x11111111@0x0 and 0x22222222@0x4, then read 0x4 and 0x0 while holding requests until ready -> reads return 0x22222222 then 0x11111111; each access takes LATENCY+2 cycles IDLE-to-IDLE; no double write.
- Misaligned read adr=0x13 -> mem_ready=1 with mem_err=1 after LATENCY edges, data_out=0. Out-of-range write adr=4*DEPTH_WORDS -> mem_err=1 and the array is unchanged (word 0 read back unaltered).
- MemRead=MemWrite=1 at adr 0x8 holding 0xA5A5A5A5 -> mem_err=1 and a later read of 0x8 returns 0xA5A5A5A5.
- Reset asserted one cycle after accepting a write of 0x12345678@0x20 (before the access edge) -> outputs are 0 immediately (async); no mem_ready pulse; read of 0x20 returns its prior value.
- LATENCY=1 build: write then read 0x40 -> mem_ready follows acceptance by exactly one edge; data correct.
